// File: rtl/mac_job_sequencer.sv
// Job-level sequencer for the MAC engine and its a/b/c/d streamers: buffers one pending
// descriptor and walks the active job through NB_ITER iterations with per-iteration address strides.
module mac_job_sequencer #(
    parameter int unsigned CNT_LEN       = 1024,
    parameter int unsigned ADDR_WIDTH    = 32,
    parameter int unsigned NB_ITER_WIDTH = 16,
    localparam int unsigned LW           = $clog2(CNT_LEN) + 1
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     clear_i,
    input  logic                     job_valid_i,
    output logic                     job_ready_o,
    input  logic [ADDR_WIDTH-1:0]    job_a_base_i,
    input  logic [ADDR_WIDTH-1:0]    job_b_base_i,
    input  logic [ADDR_WIDTH-1:0]    job_c_base_i,
    input  logic [ADDR_WIDTH-1:0]    job_d_base_i,
    input  logic [ADDR_WIDTH-1:0]    job_stride_i,
    input  logic [NB_ITER_WIDTH-1:0] job_nb_iter_i,
    input  logic [LW-1:0]            job_len_i,
    input  logic [4:0]               job_shift_i,
    input  logic                     job_simple_mul_i,
    output logic                     eng_clear_o,
    output logic                     eng_start_o,
    output logic                     eng_enable_o,
    output logic [LW-1:0]            eng_len_o,
    output logic [4:0]               eng_shift_o,
    output logic                     eng_simple_mul_o,
    input  logic                     eng_acc_valid_i,
    input  logic                     strm_ready_i,
    output logic                     strm_start_o,
    output logic [ADDR_WIDTH-1:0]    strm_a_addr_o,
    output logic [ADDR_WIDTH-1:0]    strm_b_addr_o,
    output logic [ADDR_WIDTH-1:0]    strm_c_addr_o,
    output logic [ADDR_WIDTH-1:0]    strm_d_addr_o,
    input  logic                     strm_sink_done_i,
    output logic                     busy_o,
    output logic                     done_o,
    output logic [NB_ITER_WIDTH-1:0] iter_idx_o
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        COMPUTE   = 3'd2,
        WAIT      = 3'd3,
        UPDATEIDX = 3'd4,
        TERMINATE = 3'd5
    } state_fsm_t;

    function automatic logic [ADDR_WIDTH-1:0] advance_addr(
        input logic [ADDR_WIDTH-1:0] addr,
        input logic [ADDR_WIDTH-1:0] stride
    );
        return addr + stride;
    endfunction

    state_fsm_t                state_r;
    state_fsm_t                next_state_s;

    logic                      pend_valid_r;
    logic                      pend_valid_next_s;
    logic [ADDR_WIDTH-1:0]     pend_a_r;
    logic [ADDR_WIDTH-1:0]     pend_b_r;
    logic [ADDR_WIDTH-1:0]     pend_c_r;
    logic [ADDR_WIDTH-1:0]     pend_d_r;
    logic [ADDR_WIDTH-1:0]     pend_stride_r;
    logic [NB_ITER_WIDTH-1:0]  pend_nb_r;
    logic [LW-1:0]             pend_len_r;
    logic [4:0]                pend_shift_r;
    logic                      pend_smul_r;

    logic [ADDR_WIDTH-1:0]     addr_a_r;
    logic [ADDR_WIDTH-1:0]     addr_b_r;
    logic [ADDR_WIDTH-1:0]     addr_c_r;
    logic [ADDR_WIDTH-1:0]     addr_d_r;
    logic [ADDR_WIDTH-1:0]     stride_r;
    logic [NB_ITER_WIDTH-1:0]  nb_iter_r;
    logic [NB_ITER_WIDTH-1:0]  iter_idx_r;
    logic [LW-1:0]             len_r;
    logic [4:0]                shift_r;
    logic                      smul_r;

    logic                      job_ready_r;
    logic                      eng_clear_r;
    logic                      eng_start_r;
    logic                      eng_enable_r;
    logic                      strm_start_r;
    logic                      busy_r;
    logic                      done_r;

    logic                      accept_s;
    logic                      consume_s;
    logic                      kick_s;
    logic                      advance_s;
    logic                      iter_inc_s;
    logic                      done_s;
    logic                      last_iter_s;

    // job_ready_r mirrors an empty slot, so an accept can never coincide with a consume.
    assign accept_s    = job_valid_i & job_ready_r & ~clear_i;
    assign last_iter_s = (iter_idx_r == (nb_iter_r - NB_ITER_WIDTH'(1)));

    // Next-state and per-cycle control strobes; clear_i overrides every transition.
    always_comb begin
        next_state_s = state_r;
        consume_s    = 1'b0;
        kick_s       = 1'b0;
        advance_s    = 1'b0;
        iter_inc_s   = 1'b0;
        done_s       = 1'b0;
        if (clear_i) begin
            next_state_s = IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (pend_valid_r) begin
                        consume_s = 1'b1;
                        if ((pend_nb_r == NB_ITER_WIDTH'(0)) || (pend_len_r == LW'(0))) begin
                            next_state_s = TERMINATE;
                        end else begin
                            next_state_s = START;
                        end
                    end else begin
                        next_state_s = IDLE;
                    end
                end
                START: begin
                    if (strm_ready_i) begin
                        kick_s       = 1'b1;
                        next_state_s = COMPUTE;
                    end else begin
                        next_state_s = START;
                    end
                end
                COMPUTE: begin
                    if (eng_acc_valid_i) begin
                        next_state_s = WAIT;
                    end else begin
                        next_state_s = COMPUTE;
                    end
                end
                WAIT: begin
                    if (strm_sink_done_i) begin
                        next_state_s = UPDATEIDX;
                    end else begin
                        next_state_s = WAIT;
                    end
                end
                UPDATEIDX: begin
                    advance_s = 1'b1;
                    if (last_iter_s) begin
                        next_state_s = TERMINATE;
                    end else begin
                        iter_inc_s   = 1'b1;
                        next_state_s = START;
                    end
                end
                TERMINATE: begin
                    done_s       = 1'b1;
                    next_state_s = IDLE;
                end
                default: begin
                    next_state_s = IDLE;
                end
            endcase
        end
    end

    // Pending slot occupancy for the next cycle.
    always_comb begin
        pend_valid_next_s = pend_valid_r;
        if (clear_i) begin
            pend_valid_next_s = 1'b0;
        end else if (accept_s) begin
            pend_valid_next_s = 1'b1;
        end else if (consume_s) begin
            pend_valid_next_s = 1'b0;
        end else begin
            pend_valid_next_s = pend_valid_r;
        end
    end

    // State, pending descriptor and registered control outputs.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_r       <= IDLE;
            pend_valid_r  <= 1'b0;
            pend_a_r      <= '0;
            pend_b_r      <= '0;
            pend_c_r      <= '0;
            pend_d_r      <= '0;
            pend_stride_r <= '0;
            pend_nb_r     <= '0;
            pend_len_r    <= '0;
            pend_shift_r  <= 5'd0;
            pend_smul_r   <= 1'b0;
            job_ready_r   <= 1'b0;
            eng_clear_r   <= 1'b0;
            eng_start_r   <= 1'b0;
            eng_enable_r  <= 1'b0;
            strm_start_r  <= 1'b0;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
        end else begin
            state_r      <= next_state_s;
            pend_valid_r <= pend_valid_next_s;
            if (accept_s) begin
                pend_a_r      <= job_a_base_i;
                pend_b_r      <= job_b_base_i;
                pend_c_r      <= job_c_base_i;
                pend_d_r      <= job_d_base_i;
                pend_stride_r <= job_stride_i;
                pend_nb_r     <= job_nb_iter_i;
                pend_len_r    <= job_len_i;
                pend_shift_r  <= job_shift_i;
                pend_smul_r   <= job_simple_mul_i;
            end
            job_ready_r  <= ~pend_valid_next_s;
            eng_clear_r  <= consume_s | iter_inc_s | clear_i;
            eng_start_r  <= kick_s;
            strm_start_r <= kick_s;
            eng_enable_r <= (next_state_s == COMPUTE);
            busy_r       <= (next_state_s != IDLE);
            done_r       <= done_s;
        end
    end

    // Active job configuration, stream addresses and iteration index; retained across clear_i.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            addr_a_r   <= '0;
            addr_b_r   <= '0;
            addr_c_r   <= '0;
            addr_d_r   <= '0;
            stride_r   <= '0;
            nb_iter_r  <= '0;
            iter_idx_r <= '0;
            len_r      <= '0;
            shift_r    <= 5'd0;
            smul_r     <= 1'b0;
        end else if (consume_s) begin
            addr_a_r   <= pend_a_r;
            addr_b_r   <= pend_b_r;
            addr_c_r   <= pend_c_r;
            addr_d_r   <= pend_d_r;
            stride_r   <= pend_stride_r;
            nb_iter_r  <= pend_nb_r;
            iter_idx_r <= '0;
            len_r      <= pend_len_r;
            shift_r    <= pend_shift_r;
            smul_r     <= pend_smul_r;
        end else if (advance_s) begin
            addr_a_r <= advance_addr(addr_a_r, stride_r);
            addr_b_r <= advance_addr(addr_b_r, stride_r);
            addr_c_r <= advance_addr(addr_c_r, stride_r);
            addr_d_r <= advance_addr(addr_d_r, stride_r);
            if (iter_inc_s) begin
                iter_idx_r <= iter_idx_r + NB_ITER_WIDTH'(1);
            end
        end
    end

    assign job_ready_o      = job_ready_r;
    assign eng_clear_o      = eng_clear_r;
    assign eng_start_o      = eng_start_r;
    assign eng_enable_o     = eng_enable_r;
    assign eng_len_o        = len_r;
    assign eng_shift_o      = shift_r;
    assign eng_simple_mul_o = smul_r;
    assign strm_start_o     = strm_start_r;
    assign strm_a_addr_o    = addr_a_r;
    assign strm_b_addr_o    = addr_b_r;
    assign strm_c_addr_o    = addr_c_r;
    assign strm_d_addr_o    = addr_d_r;
    assign busy_o           = busy_r;
    assign done_o           = done_r;
    assign iter_idx_o       = iter_idx_r;

endmodule
